// File: rtl/sarray_tinst_sched.sv
// ============================================================================
//  sarray_tinst_sched
//  Tile-instruction scheduler: in-order queue with A-buffer ping-pong and
//  array-drain hazard gating ahead of sarray_top.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sarray_tinst_sched #(
    parameter int ADDR_WIDTH   = 64,
    parameter int TYPE_WIDTH   = 2,
    parameter int PREC_WIDTH   = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int DRAIN_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [TYPE_WIDTH-1:0] in_type_i,
    input  logic [ADDR_WIDTH-1:0] in_addr0_i,
    input  logic [ADDR_WIDTH-1:0] in_addr1_i,
    input  logic [PREC_WIDTH-1:0] in_prec_i,
    input  logic                  in_acc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [TYPE_WIDTH-1:0] out_type_o,
    output logic [ADDR_WIDTH-1:0] out_addr0_o,
    output logic [ADDR_WIDTH-1:0] out_addr1_o,
    output logic [PREC_WIDTH-1:0] out_prec_o,
    output logic                  out_acc_o,
    output logic                  out_abuf_id_o,
    input  logic                  done_i,
    output logic [1:0]            abuf_valid_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [TYPE_WIDTH-1:0] T_TMMA     = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] T_PRELOADA = TYPE_WIDTH'(1);

    logic [TYPE_WIDTH-1:0] q_type [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr0[FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr1[FIFO_DEPTH];
    logic [PREC_WIDTH-1:0] q_prec [FIFO_DEPTH];
    logic                  q_acc  [FIFO_DEPTH];

    logic [PTR_W-1:0]      q_wr;
    logic [PTR_W-1:0]      q_rd;
    logic [CNT_W-1:0]      q_cnt;

    logic                  inflight;
    logic [TYPE_WIDTH-1:0] inflight_type;
    logic [1:0]            abuf_valid;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [7:0]            drain_cnt;
    logic                  err;

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  hazard_ok;
    logic                  abuf_id;
    logic                  deadlock;
    logic                  done_ok;
    logic [TYPE_WIDTH-1:0] head_type;

    always_comb begin
        empty     = (q_cnt == '0);
        full      = (q_cnt == CNT_W'(FIFO_DEPTH));
        head_type = q_type[q_rd];
        hazard_ok = 1'b0;
        abuf_id   = 1'b0;
        if (head_type == T_TMMA) begin
            hazard_ok = abuf_valid[rd_ptr];
            abuf_id   = rd_ptr;
        end else if (head_type == T_PRELOADA) begin
            hazard_ok = ~abuf_valid[wr_ptr];
            abuf_id   = wr_ptr;
        end else begin
            hazard_ok = (drain_cnt == 8'd0);
        end
        // Both conditions can never resolve on their own: nothing is in flight
        // to produce the done that would free or fill a buffer.
        deadlock = ~empty & ~inflight &
                   (((head_type == T_TMMA) & (abuf_valid == 2'b00)) |
                    ((head_type == T_PRELOADA) & (abuf_valid == 2'b11)));
        push     = in_valid_i & ~full;
        pop      = out_valid_o & out_ready_i;
        done_ok  = done_i & inflight;
    end

    assign in_ready_o    = ~full;
    assign out_valid_o   = ~empty & ~inflight & hazard_ok;
    assign out_type_o    = head_type;
    assign out_addr0_o   = q_addr0[q_rd];
    assign out_addr1_o   = q_addr1[q_rd];
    assign out_prec_o    = q_prec[q_rd];
    assign out_acc_o     = q_acc[q_rd];
    assign out_abuf_id_o = out_valid_o ? abuf_id : 1'b0;
    assign abuf_valid_o  = abuf_valid;
    assign busy_o        = ~empty | inflight | (drain_cnt != 8'd0);
    assign err_o         = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_type[i]  <= '0;
                q_addr0[i] <= '0;
                q_addr1[i] <= '0;
                q_prec[i]  <= '0;
                q_acc[i]   <= 1'b0;
            end
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else begin
            if (push) begin
                q_type[q_wr]  <= in_type_i;
                q_addr0[q_wr] <= in_addr0_i;
                q_addr1[q_wr] <= in_addr1_i;
                q_prec[q_wr]  <= in_prec_i;
                q_acc[q_wr]   <= in_acc_i;
                q_wr          <= q_wr + PTR_W'(1);
            end
            if (pop) begin
                q_rd <= q_rd + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + CNT_W'(1);
                2'b01:   q_cnt <= q_cnt - CNT_W'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_type <= '0;
            abuf_valid    <= 2'b00;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            drain_cnt     <= 8'd0;
            err           <= 1'b0;
        end else begin
            if (pop) begin
                inflight      <= 1'b1;
                inflight_type <= head_type;
            end else if (done_ok) begin
                inflight <= 1'b0;
            end

            if (done_ok && inflight_type == T_PRELOADA) begin
                abuf_valid[wr_ptr] <= 1'b1;
                wr_ptr             <= ~wr_ptr;
            end
            if (done_ok && inflight_type == T_TMMA) begin
                abuf_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= ~rd_ptr;
                drain_cnt          <= 8'(DRAIN_CYCLES);
            end else if (drain_cnt != 8'd0) begin
                drain_cnt <= drain_cnt - 8'd1;
            end

            if (deadlock) begin
                err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sarray_tinst_sched.sv
// Scoreboard bench for sarray_tinst_sched: expected issues are queued by the
// stimulus and popped by a monitor on every output handshake.
`default_nettype none

module tb_sarray_tinst_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_type = '0;
    logic [63:0] in_addr0 = '0;
    logic [63:0] in_addr1 = '0;
    logic [0:0]  in_prec = '0;
    logic        in_acc = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_type;
    logic [63:0] out_addr0;
    logic [63:0] out_addr1;
    logic [0:0]  out_prec;
    logic        out_acc;
    logic        out_abuf_id;
    logic        done = 1'b0;
    logic [1:0]  abuf_valid;
    logic        busy;
    logic        err;

    sarray_tinst_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_type_i    (in_type),
        .in_addr0_i   (in_addr0),
        .in_addr1_i   (in_addr1),
        .in_prec_i    (in_prec),
        .in_acc_i     (in_acc),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_type_o   (out_type),
        .out_addr0_o  (out_addr0),
        .out_addr1_o  (out_addr1),
        .out_prec_o   (out_prec),
        .out_acc_o    (out_acc),
        .out_abuf_id_o(out_abuf_id),
        .done_i       (done),
        .abuf_valid_o (abuf_valid),
        .busy_o       (busy),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  t;
        logic [63:0] a0;
        logic [63:0] a1;
        logic        p;
        logic        acc;
        logic        id;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   hsk_cnt = 0;

    task automatic check(input string name, input logic [139:0] act, input logic [139:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Monitor: samples the handshake on the falling edge, ahead of the rising edge that commits it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            exp_t g;
            hsk_cnt++;
            g = '{out_type, out_addr0, out_addr1, out_prec, out_acc, out_abuf_id};
            if (sbq.size() == 0) e = '1;
            else e = sbq.pop_front();
            check("issue", 140'(g), 140'(e));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [1:0] t, input logic [63:0] a0, input logic [63:0] a1,
                        input logic p, input logic acc);
        in_valid = 1'b1;
        in_type  = t;
        in_addr0 = a0;
        in_addr1 = a1;
        in_prec  = p;
        in_acc   = acc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_issue(input logic [1:0] t, input logic [63:0] a0, input logic [63:0] a1,
                                input logic p, input logic acc, input logic id);
        sbq.push_back('{t, a0, a1, p, acc, id});
    endtask

    task automatic wait_hsk(input int target);
        for (int i = 0; i < 200 && hsk_cnt < target; i++) tick();
        check("hsk_count", 140'(hsk_cnt), 140'(target));
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        int cycles;
        int acc_n;
        int base;

        do_reset();
        check("rst_in_ready", 140'(in_ready), 140'(1));
        check("rst_out_valid", 140'(out_valid), 140'(0));
        check("rst_busy", 140'(busy), 140'(0));
        check("rst_err", 140'(err), 140'(0));
        check("rst_abuf", 140'(abuf_valid), 140'(0));

        // PRELOADA then TMMA, each completed before the next.
        out_ready = 1'b1;
        expect_issue(2'd1, 64'h1000, 64'h0, 1'b0, 1'b0, 1'b0);
        push(2'd1, 64'h1000, 64'h0, 1'b0, 1'b0);
        wait_hsk(1);
        pulse_done();
        check("abuf_after_pa", 140'(abuf_valid), 140'(2'b01));
        expect_issue(2'd0, 64'h0, 64'h2000, 1'b1, 1'b1, 1'b0);
        push(2'd0, 64'h0, 64'h2000, 1'b1, 1'b1);
        wait_hsk(2);
        pulse_done();
        check("abuf_after_tmma", 140'(abuf_valid), 140'(2'b00));
        check("busy_draining", 140'(busy), 140'(1));

        // STOREC waits out the 32-cycle drain that the TMMA done started.
        out_ready = 1'b0;
        push(2'd3, 64'h3000, 64'h0, 1'b0, 1'b0);
        cycles = 1;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        check("drain_latency", 140'(cycles), 140'(32));
        expect_issue(2'd3, 64'h3000, 64'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        wait_hsk(3);
        pulse_done();
        check("busy_idle", 140'(busy), 140'(0));

        // Queue fill with the consumer stalled.
        out_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_type  = 2'd2;
            in_addr0 = 64'h100 + 64'(i);
            in_addr1 = 64'h0;
            in_prec  = 1'b0;
            in_acc   = 1'b0;
            if (in_ready) begin
                acc_n++;
                expect_issue(2'd2, 64'h100 + 64'(i), 64'h0, 1'b0, 1'b0, 1'b0);
            end
            tick();
        end
        in_valid = 1'b0;
        check("fifo_accepted", 140'(acc_n), 140'(4));
        check("fifo_full", 140'(in_ready), 140'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fifo_slot_freed", 140'(in_ready), 140'(1));
        base = 4;
        pulse_done();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_hsk(base + i + 1);
            pulse_done();
        end

        // Three PRELOADAs ahead of a TMMA: the third can never issue.
        do_reset();
        out_ready = 1'b0;
        base = hsk_cnt;
        expect_issue(2'd1, 64'h10, 64'h0, 1'b0, 1'b0, 1'b0);
        expect_issue(2'd1, 64'h20, 64'h0, 1'b0, 1'b0, 1'b1);
        push(2'd1, 64'h10, 64'h0, 1'b0, 1'b0);
        push(2'd1, 64'h20, 64'h0, 1'b0, 1'b0);
        push(2'd1, 64'h30, 64'h0, 1'b0, 1'b0);
        push(2'd0, 64'h0, 64'h40, 1'b0, 1'b0);
        out_ready = 1'b1;
        wait_hsk(base + 1);
        pulse_done();
        wait_hsk(base + 2);
        pulse_done();
        tick();
        tick();
        tick();
        check("dl_pa_err", 140'(err), 140'(1));
        check("dl_pa_stall", 140'(out_valid), 140'(0));
        check("dl_pa_no_issue", 140'(hsk_cnt), 140'(base + 2));
        check("dl_pa_abuf", 140'(abuf_valid), 140'(2'b11));

        // TMMA at head with no loaded buffer.
        do_reset();
        push(2'd0, 64'h0, 64'h50, 1'b0, 1'b0);
        check("dl_tmma_err_pre", 140'(err), 140'(0));
        tick();
        check("dl_tmma_err", 140'(err), 140'(1));
        check("dl_tmma_stall", 140'(out_valid), 140'(0));

        // Asynchronous reset with a TMMA in flight and three entries queued.
        do_reset();
        base = hsk_cnt;
        expect_issue(2'd1, 64'h500, 64'h0, 1'b0, 1'b0, 1'b0);
        push(2'd1, 64'h500, 64'h0, 1'b0, 1'b0);
        wait_hsk(base + 1);
        pulse_done();
        expect_issue(2'd0, 64'h0, 64'h600, 1'b0, 1'b1, 1'b0);
        push(2'd0, 64'h0, 64'h600, 1'b0, 1'b1);
        wait_hsk(base + 2);
        push(2'd2, 64'h700, 64'h0, 1'b0, 1'b0);
        push(2'd2, 64'h710, 64'h0, 1'b0, 1'b0);
        push(2'd2, 64'h720, 64'h0, 1'b0, 1'b0);
        check("pre_rst_busy", 140'(busy), 140'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_in_ready", 140'(in_ready), 140'(1));
        check("async_out_valid", 140'(out_valid), 140'(0));
        check("async_busy", 140'(busy), 140'(0));
        check("async_abuf", 140'(abuf_valid), 140'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pulse_done();
        tick();
        check("post_rst_done_busy", 140'(busy), 140'(0));
        check("post_rst_done_abuf", 140'(abuf_valid), 140'(0));
        check("sb_drained", 140'(sbq.size()), 140'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
